// File: rtl/debounce_pkg.sv
//==============================================================================
// Module  : debounce_pkg
// Purpose : Shared types and defaults for the input-conditioning blocks.
//           - db_state_t         : debounce FSM state encoding
//           - DB_SYNC_STAGES_DEF : default synchronizer depth
//           - DB_CYCLES_DEF      : default stable-cycle qualification count
//           - dbCntWidth()       : qualification counter width (min 1 bit)
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package debounce_pkg;

   // Two IDLE states hold the current level; two CHECK states qualify a
   // candidate change towards the opposite level.
   typedef enum logic [1:0] {
      IDLE_LOW   = 2'd0,
      CHECK_HIGH = 2'd1,
      IDLE_HIGH  = 2'd2,
      CHECK_LOW  = 2'd3
   } db_state_t;

   localparam int DB_SYNC_STAGES_DEF = 2;
   localparam int DB_CYCLES_DEF      = 16;

   function automatic int dbCntWidth(input int cycles);
      int w;
      w = $clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage : debounce_pkg

`default_nettype wire

// File: rtl/sync_chain.sv
//==============================================================================
// Module  : sync_chain
// Purpose : STAGES-deep flop chain bringing an asynchronous level into the
//           clock domain. Reusable by any input-conditioning block.
// Ports   : clock   in  clock
//           reset   in  asynchronous active-high reset (chain clears to 0)
//           i_data  in  asynchronous input level
//           o_sync  out synchronized level (last flop)
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic i_data,
   output logic o_sync
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_data};
      end
   end

   assign o_sync = r_chain[STAGES-1];

endmodule : sync_chain

`default_nettype wire

// File: rtl/input_debounce.sv
//==============================================================================
// Module  : input_debounce
// Purpose : Conditions one raw asynchronous switch/button input into a clean
//           level. The input is synchronized, then a 4-state FSM only moves
//           `debounced` after the synchronized value has held a new level for
//           DEBOUNCE_CYCLES consecutive clocks.
// Ports   : clock        in   single clock
//           reset        in   asynchronous active-high reset
//           rawIn        in   raw asynchronous input
//           debounced    out  filtered level (registered)
//           checking     out  high while a candidate change is qualifying
//           glitchCount  out  [GLITCH_W] saturating count of rejected changes
//                             (only when DEBOUNCE_GLITCH_CNT_EN is defined)
// Config  : `define DEBOUNCE_GLITCH_CNT_EN to build the glitch counter/port.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module input_debounce
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = DB_SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DB_CYCLES_DEF,
   parameter int GLITCH_W        = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                rawIn,
   output logic                debounced,
   output logic                checking
`ifdef DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [GLITCH_W-1:0] glitchCount
`endif
);

   localparam int                 c_CNT_W    = dbCntWidth(DEBOUNCE_CYCLES);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic               w_sync;
   db_state_t          r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_debounced;

   // rawIn is sampled nowhere else: everything downstream sees w_sync only.
   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clock  (clock),
      .reset  (reset),
      .i_data (rawIn),
      .o_sync (w_sync)
   );

   // cnt counts consecutive cycles the new value has been seen, including the
   // cycle that entered CHECK; hitting DEBOUNCE_CYCLES-1 while the value still
   // holds is therefore the DEBOUNCE_CYCLES-th consecutive sample.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE_LOW;
         r_cnt       <= '0;
         r_debounced <= 1'b0;
      end else begin
         case (r_state)
            IDLE_LOW: begin
               if (w_sync) begin
                  r_state <= CHECK_HIGH;
                  r_cnt   <= c_CNT_ONE;
               end else begin
                  r_cnt   <= '0;
               end
            end
            CHECK_HIGH: begin
               if (!w_sync) begin
                  r_state     <= IDLE_LOW;
                  r_cnt       <= '0;
               end else if (r_cnt == c_CNT_LAST) begin
                  r_state     <= IDLE_HIGH;
                  r_debounced <= 1'b1;
                  r_cnt       <= '0;
               end else begin
                  r_cnt       <= r_cnt + c_CNT_ONE;
               end
            end
            IDLE_HIGH: begin
               if (!w_sync) begin
                  r_state <= CHECK_LOW;
                  r_cnt   <= c_CNT_ONE;
               end else begin
                  r_cnt   <= '0;
               end
            end
            CHECK_LOW: begin
               if (w_sync) begin
                  r_state     <= IDLE_HIGH;
                  r_cnt       <= '0;
               end else if (r_cnt == c_CNT_LAST) begin
                  r_state     <= IDLE_LOW;
                  r_debounced <= 1'b0;
                  r_cnt       <= '0;
               end else begin
                  r_cnt       <= r_cnt + c_CNT_ONE;
               end
            end
            default: begin
               // Recovery from a corrupted state register.
               r_state     <= IDLE_LOW;
               r_cnt       <= '0;
               r_debounced <= 1'b0;
            end
         endcase
      end
   end

   assign debounced = r_debounced;
   assign checking  = (r_state == CHECK_HIGH) || (r_state == CHECK_LOW);

`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic                w_abort;
   logic [GLITCH_W-1:0] r_glitchCount;

   // An abort is a CHECK state seeing the synchronized input fall back to the
   // level it started from.
   assign w_abort = ((r_state == CHECK_HIGH) && !w_sync) ||
                    ((r_state == CHECK_LOW)  &&  w_sync);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_glitchCount <= '0;
      end else if (w_abort && (r_glitchCount != '1)) begin
         r_glitchCount <= r_glitchCount + 1'b1;
      end
   end

   assign glitchCount = r_glitchCount;
`endif

endmodule : input_debounce

`default_nettype wire

// File: tb/tb_input_debounce.sv
//==============================================================================
// Module  : tb_input_debounce
// Purpose : Self-checking bench for input_debounce. A run-length reference
//           model predicts debounced/checking/glitchCount every cycle; directed
//           scenarios add literal expectations, then random stimulus follows.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_input_debounce;

   localparam int SYNC_STAGES     = 2;
   localparam int DEBOUNCE_CYCLES = 16;
   localparam int GLITCH_W        = 8;
   localparam int c_GLITCH_MAX    = (1 << GLITCH_W) - 1;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic rawIn = 1'b0;
   logic debounced;
   logic checking;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [GLITCH_W-1:0] glitchCount;
`endif

   input_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .GLITCH_W        (GLITCH_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .rawIn       (rawIn),
      .debounced   (debounced),
      .checking    (checking)
`ifdef DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitchCount (glitchCount)
`endif
   );

   always #5 clock = ~clock;

   int nCompared = 0;
   int nMismatch = 0;

   task automatic check(input string name, input int act, input int exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // mHist[0] is the newest raw sample; the value the filter sees at an edge is
   // the raw level sampled SYNC_STAGES edges earlier. mRun counts consecutive
   // filter samples that disagree with the current output level.
   bit mHist[SYNC_STAGES];
   bit mDeb;
   int mRun;
   int mGlitch;

   task automatic modelReset();
      for (int i = 0; i < SYNC_STAGES; i++) mHist[i] = 1'b0;
      mDeb    = 1'b0;
      mRun    = 0;
      mGlitch = 0;
   endtask

   task automatic modelStep(input bit raw);
      bit s;
      s = mHist[SYNC_STAGES-1];
      for (int i = SYNC_STAGES-1; i > 0; i--) mHist[i] = mHist[i-1];
      mHist[0] = raw;
      if (s != mDeb) begin
         mRun++;
         if (mRun == DEBOUNCE_CYCLES) begin
            mDeb = s;
            mRun = 0;
         end
      end else begin
         if (mRun > 0 && mGlitch < c_GLITCH_MAX) mGlitch++;
         mRun = 0;
      end
   endtask

   // ---------------- compare process ----------------
   initial begin
      modelReset();
      forever begin
         @(posedge clock or posedge reset);
         if (reset) modelReset();
         else       modelStep(rawIn);
         #1;
         check("debounced", int'(debounced), int'(mDeb));
         check("checking",  int'(checking),  int'(mRun != 0));
`ifdef DEBOUNCE_GLITCH_CNT_EN
         check("glitchCount", int'(glitchCount), mGlitch);
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit v, input int n);
      rawIn = v;
      repeat (n) @(negedge clock);
   endtask

   // Raise rawIn at a negedge and count posedges until debounced rises.
   task automatic measureRise(output int edges, output int chkCycles);
      edges     = 0;
      chkCycles = 0;
      rawIn     = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         edges++;
         #1;
         if (debounced) break;
         chkCycles += int'(checking);
      end
      @(negedge clock);
   endtask

   int edges, chk, hiCnt;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   int g0;
`endif

   initial begin
      // Reset asserted mid-cycle with rawIn high: outputs clear immediately.
      rawIn = 1'b1;
      #2 reset = 1'b1;
      #1;
      check("reset_debounced", int'(debounced), 0);
      check("reset_checking",  int'(checking),  0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("reset_glitch",    int'(glitchCount), 0);
`endif
      rawIn = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      drive(1'b0, 5);

      // Clean rise: 18 edges, checking for the 15 edges before.
      measureRise(edges, chk);
      check("clean_rise_latency", edges, 18);
      check("clean_rise_checking", chk, 15);
      drive(1'b1, 5);
      drive(1'b0, 30);
      check("clean_fall_level", int'(debounced), 0);

      // Threshold pulse: exactly DEBOUNCE_CYCLES high -> output high 16 clocks.
      hiCnt = 0;
      for (int i = 0; i < 60; i++) begin
         rawIn = (i < 16);
         @(negedge clock);
         hiCnt += int'(debounced);
      end
      check("threshold_pulse_width", hiCnt, 16);

      // Just-short pulse: one cycle fewer is rejected.
`ifdef DEBOUNCE_GLITCH_CNT_EN
      g0 = int'(glitchCount);
`endif
      hiCnt = 0;
      for (int i = 0; i < 40; i++) begin
         rawIn = (i < 15);
         @(negedge clock);
         hiCnt += int'(debounced);
      end
      check("short_pulse_width", hiCnt, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("short_pulse_glitch", int'(glitchCount) - g0, 1);
`endif

      // Bounce burst then hold: single rise 18 edges after the final rise.
`ifdef DEBOUNCE_GLITCH_CNT_EN
      g0 = int'(glitchCount);
`endif
      for (int p = 0; p < 5; p++) begin
         drive(1'b1, 3);
         drive(1'b0, 3);
      end
      measureRise(edges, chk);
      check("bounce_rise_latency", edges, 18);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("bounce_glitches", int'(glitchCount) - g0, 5);
`endif
      drive(1'b1, 5);
      drive(1'b0, 30);

      // Saturation: 300 rejected 2-clock glitches.
      for (int p = 0; p < 300; p++) begin
         drive(1'b1, 2);
         drive(1'b0, 2);
      end
      drive(1'b0, 4);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("glitch_saturated", int'(glitchCount), 255);
`endif

      // Reset in the middle of a check.
      drive(1'b1, 10);
      check("midcheck_checking", int'(checking), 1);
      #2 reset = 1'b1;
      #1;
      check("midcheck_reset_checking",  int'(checking),  0);
      check("midcheck_reset_debounced", int'(debounced), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("midcheck_reset_glitch",    int'(glitchCount), 0);
`endif
      @(negedge clock);
      @(negedge clock);
      rawIn = 1'b0;
      reset = 1'b0;
      drive(1'b0, 5);

      // Randomized segments with occasional asynchronous resets.
      for (int seg = 0; seg < 200; seg++) begin
         if ($urandom_range(0, 29) == 0) begin
            #2 reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
         end else begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 24)));
         end
      end
      drive(1'b0, 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule : tb_input_debounce

`default_nettype wire

// File: doc/input_debounce.md
Name: input_debounce

Overview:
- Conditions one raw asynchronous input (switch or button) into a clean, glitch-free level.
- Its `debounced` output drives the `anyEdge` input of the downstream edge-detect stage.
- Internals: an N-flop synchronizer followed by a counter-qualified 4-state FSM.
- `debounced` changes only after the synchronized input has held a new value for DEBOUNCE_CYCLES consecutive clocks.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range >= 2.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before `debounced` changes; legal range >= 2.
- GLITCH_W, 8, width of the rejected-glitch counter; used only with DEBOUNCE_GLITCH_CNT_EN.

Ports:
- clock  input  1  single clock for all state.
- reset  input  1  asynchronous, active-high reset.
- rawIn  input  1  asynchronous raw input; no timing relation to `clock`.
- debounced  output  1  filtered level; feeds the edge detector's `anyEdge`.
- checking  output  1  high while the FSM is qualifying a candidate change (CHECK_HIGH or CHECK_LOW).
- glitchCount  output  GLITCH_W  present only with DEBOUNCE_GLITCH_CNT_EN; count of rejected candidate changes.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-high; ports are named `clock` and `reset`.
- Reset values:
  - all sync flops = 0;
  - state = IDLE_LOW;
  - cnt = 0;
  - `debounced` = 0;
  - `checking` = 0;
  - `glitchCount` = 0.
- Synchronizer: `rawIn` is shifted through SYNC_STAGES flops. `s` is the last flop's output. No other logic samples `rawIn`.
- Counter: cnt width = $clog2(DEBOUNCE_CYCLES), with a minimum of 1 bit.
- FSM, evaluated at each posedge when reset is low:
  - IDLE_LOW (`debounced`=0):
    - s=1 -> CHECK_HIGH, cnt <= 1;
    - otherwise stay, cnt <= 0.
  - CHECK_HIGH (`debounced`=0):
    - s=0 -> IDLE_LOW, cnt <= 0, glitch event;
    - else if cnt == DEBOUNCE_CYCLES-1 -> IDLE_HIGH, `debounced` <= 1, cnt <= 0;
    - else cnt <= cnt+1.
  - IDLE_HIGH and CHECK_LOW: mirror images of the above with the polarities inverted.
- Outputs:
  - `debounced` is a registered output; it changes only on a CHECK -> IDLE completion transition.
  - `checking` = (state == CHECK_HIGH or CHECK_LOW), decoded directly from the state register.
- Latency: a clean `rawIn` step held long enough makes `debounced` change exactly SYNC_STAGES+DEBOUNCE_CYCLES clocks after the first posedge that samples the new value. With defaults this is 18 clocks.
- Boundary conditions:
  - Minimum accepted pulse: s must hold the new value for exactly DEBOUNCE_CYCLES consecutive posedges. One cycle fewer is rejected and `debounced` is unchanged.
  - Glitch during CHECK: return to the originating IDLE state and clear cnt. There is no partial credit; a new check restarts from cnt=1.
  - `debounced` never toggles twice within DEBOUNCE_CYCLES clocks.
  - Reset asserted mid-check: immediate return to the reset values; no glitch is counted.
  - Reset release: the FSM starts in IDLE_LOW. If `rawIn` is already high, a normal CHECK_HIGH follows, so `debounced` rises after SYNC_STAGES+DEBOUNCE_CYCLES clocks. Downstream therefore sees one rising edge, which is the intended behaviour.
- The FSM encoding is unreachable-safe: any illegal state recovers to IDLE_LOW on the next clock.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - the `glitchCount` port exists;
  - it increments by 1 on each CHECK -> originating-IDLE abort;
  - it saturates at 2^GLITCH_W-1 and does not wrap;
  - it is cleared only by reset.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package `debounce_pkg`:
  - typedef enum `db_state_t` {IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW};
  - default parameter constants DB_SYNC_STAGES_DEF=2 and DB_CYCLES_DEF=16.
- Sub-module `sync_chain`: a parameterized SYNC_STAGES-deep flop chain with asynchronous reset to 0, reusable by other input-conditioning blocks.

Test Plan (defaults: SYNC_STAGES=2, DEBOUNCE_CYCLES=16, GLITCH_W=8):
- Reset check: assert `reset` mid-cycle with `rawIn`=1 -> `debounced`=0, `checking`=0 and `glitchCount`=0 immediately, without waiting for a clock edge.
- Clean rise: `rawIn` 0->1 and held -> `debounced`=1 exactly 18 clocks later; `checking`=1 for the 15 clocks before that.
- Threshold pulse: `rawIn` high for exactly 16 clocks, then low for 40 -> `debounced` high for exactly 16 clocks.
- Just-short pulse: `rawIn` high for 15 clocks -> `debounced` stays 0; `glitchCount`=1 (with the macro defined).
- Bounce burst: 5 pulses of 3 clocks high / 3 clocks low, then held high -> a single `debounced` rise 18 clocks after the final rising sample; `glitchCount`=5.
- Saturation: 300 rejected 2-clock glitches -> `glitchCount`=255. Then reset mid-check -> state IDLE_LOW and `glitchCount`=0.
